// File: rtl/lcd_msg_arbiter.sv
// rtl/lcd_msg_arbiter.sv - round-robin arbiter sharing one 16-character LCD line writer
module lcd_msg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int WR_TIMEOUT  = 4_000_000
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [N_REQ-1:0]       iREQ,
  input  logic [128*N_REQ-1:0]   iMSG,
  input  logic                   iWR_DONE,
  output logic [N_REQ-1:0]       oACK,
  output logic [127:0]           oSTRING,
  output logic                   oLOAD,
  output logic [2:0]             oOWNER,
  output logic                   oBUSY,
  output logic                   oERR
);

  // One counter serves both the write timeout and the hold time.
  localparam int CNT_MAX = (HOLD_CYCLES > WR_TIMEOUT) ? HOLD_CYCLES : WR_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [127:0]  BLANK     = {16{8'h20}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_WR,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      last_owner;
  logic [2:0]      sel;
  logic            found;
  int              cand;

  // Round-robin pick: first requester after the last owner, wrapping around.
  always_comb begin
    sel   = last_owner;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_owner) + i) % N_REQ;
      if (!found && (|(iREQ & (N_REQ'(1) << cand)))) begin
        sel   = 3'(cand);
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (found) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_WAIT_WR;
      S_WAIT_WR: if (iWR_DONE || (cnt == WR_LAST)) state_nxt = S_HOLD;
      S_HOLD:    if (cnt == HOLD_LAST) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Capture, handshake pulses, shared counter and sticky timeout flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSTRING    <= BLANK;
      oACK       <= '0;
      oLOAD      <= 1'b0;
      oOWNER     <= 3'd0;
      oERR       <= 1'b0;
      last_owner <= 3'(N_REQ - 1);
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            oSTRING    <= iMSG[128*int'(sel) +: 128];
            oOWNER     <= sel;
            last_owner <= sel;
            oACK       <= N_REQ'(1) << sel;
          end
        end
        S_LOAD: begin
          oACK  <= '0;
          oLOAD <= 1'b1;
        end
        S_WAIT_WR: begin
          oLOAD <= 1'b0;
          if (iWR_DONE) begin
            cnt <= '0;
          end else if (cnt == WR_LAST) begin
            oERR <= 1'b1;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign oBUSY = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// tb/tb_lcd_msg_arbiter.sv - directed self-checking bench for lcd_msg_arbiter
module tb_lcd_msg_arbiter;

  localparam int N_REQ = 4;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic                 iCLK;
  logic                 iRST;
  logic [N_REQ-1:0]     iREQ;
  logic [128*N_REQ-1:0] iMSG;
  logic                 iWR_DONE;
  logic [N_REQ-1:0]     oACK;
  logic [127:0]         oSTRING;
  logic                 oLOAD;
  logic [2:0]           oOWNER;
  logic                 oBUSY;
  logic                 oERR;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lcd_msg_arbiter #(
    .N_REQ       (N_REQ),
    .HOLD_CYCLES (8),
    .WR_TIMEOUT  (16)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iREQ     (iREQ),
    .iMSG     (iMSG),
    .iWR_DONE (iWR_DONE),
    .oACK     (oACK),
    .oSTRING  (oSTRING),
    .oLOAD    (oLOAD),
    .oOWNER   (oOWNER),
    .oBUSY    (oBUSY),
    .oERR     (oERR)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
    cyc++;
  endtask

  task automatic set_msg(input int k, input logic [127:0] m);
    iMSG[128*k +: 128] = m;
  endtask

  task automatic wait_ack();
    int k;
    k = 0;
    step();
    while (oACK == '0 && k < 40) begin
      step();
      k++;
    end
    chk("ack_wait_bound", {127'd0, oACK != '0}, 128'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (oBUSY && k < 40) begin
      step();
      k++;
    end
    chk("idle_wait_bound", {127'd0, oBUSY}, 128'd0);
  endtask

  logic [127:0] exp_msg [4];
  logic [127:0] s_guess;
  logic [127:0] s_orig;
  logic [127:0] s_changed;
  logic [127:0] s_tmo;
  int           last_cyc;
  logic         ack_seen;

  initial begin
    exp_msg[0] = "SOURCE 0 READY  ";
    exp_msg[1] = "SOURCE 1 READY  ";
    exp_msg[2] = "SOURCE 2 READY  ";
    exp_msg[3] = "SOURCE 3 READY  ";
    s_guess    = "GUESS: 42       ";
    s_orig     = "LATE ORIGINAL   ";
    s_changed  = "LATE CHANGED    ";
    s_tmo      = "TIMEOUT CASE    ";
    iRST = 1'b1;
    iREQ = '0;
    iMSG = '0;
    iWR_DONE = 1'b0;

    // Reset
    step();
    step();
    chk("rst_string", oSTRING, BLANK);
    chk("rst_ack",    oACK,   0);
    chk("rst_load",   oLOAD,  0);
    chk("rst_owner",  oOWNER, 0);
    chk("rst_busy",   oBUSY,  0);
    chk("rst_err",    oERR,   0);
    iRST = 1'b0;

    // Single request from source 2
    set_msg(2, s_guess);
    iREQ = 4'b0100;
    step();
    chk("single_ack",    oACK,    4'b0100);
    chk("single_owner",  oOWNER,  2);
    chk("single_string", oSTRING, s_guess);
    chk("single_busy",   oBUSY,   1);
    chk("single_load0",  oLOAD,   0);
    iREQ = '0;
    step();
    chk("single_ack_drop", oACK,  0);
    chk("single_load",     oLOAD, 1);
    step();
    chk("single_load_drop", oLOAD, 0);
    step();
    step();
    iWR_DONE = 1'b1;
    step();
    iWR_DONE = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("single_busy_hold7", oBUSY, 1);
    step();
    chk("single_busy_hold8", oBUSY, 1);
    step();
    chk("single_busy_drop", oBUSY, 0);
    chk("single_string_kept", oSTRING, s_guess);

    // Round robin after a fresh reset
    iRST = 1'b1;
    step();
    step();
    iRST = 1'b0;
    for (int k = 0; k < 4; k++) set_msg(k, exp_msg[k]);
    iREQ = 4'b1111;
    iWR_DONE = 1'b1;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ack();
      chk($sformatf("rr_ack%0d", g), oACK, 128'd1 << (g % 4));
      chk($sformatf("rr_string%0d", g), oSTRING, exp_msg[g % 4]);
      if (g > 0) chk($sformatf("rr_gap%0d", g), cyc - last_cyc, 11);
      last_cyc = cyc;
    end
    iREQ = '0;
    step();
    wait_idle();
    iWR_DONE = 1'b0;

    // Late change of message and request while the writer runs
    set_msg(0, s_orig);
    iREQ = 4'b0001;
    step();
    chk("late_ack",    oACK,    4'b0001);
    chk("late_string", oSTRING, s_orig);
    step();
    step();
    set_msg(0, s_changed);
    iREQ = '0;
    step();
    step();
    step();
    chk("late_string_wait", oSTRING, s_orig);
    iWR_DONE = 1'b1;
    step();
    iWR_DONE = 1'b0;
    ack_seen = 1'b0;
    for (int k = 0; k < 20 && oBUSY; k++) begin
      ack_seen = ack_seen | (|oACK);
      step();
    end
    step();
    ack_seen = ack_seen | (|oACK);
    chk("late_no_ack",     ack_seen, 0);
    chk("late_idle",       oBUSY,    0);
    chk("late_string_end", oSTRING,  s_orig);

    // Write timeout
    set_msg(1, s_tmo);
    iREQ = 4'b0010;
    step();
    chk("tmo_ack",   oACK,   4'b0010);
    chk("tmo_owner", oOWNER, 1);
    iREQ = '0;
    step();
    chk("tmo_load", oLOAD, 1);
    for (int i = 0; i < 15; i++) step();
    chk("tmo_err_early", oERR, 0);
    step();
    chk("tmo_err_set", oERR,  1);
    chk("tmo_busy",    oBUSY, 1);
    for (int i = 0; i < 7; i++) step();
    chk("tmo_hold_busy", oBUSY, 1);
    step();
    chk("tmo_idle", oBUSY, 0);
    step();
    step();
    chk("tmo_err_sticky", oERR, 1);

    // Reset in the middle of HOLD
    iREQ = 4'b0011;
    step();
    chk("mid_ack0", oACK, 4'b0001);
    iWR_DONE = 1'b1;
    step();
    step();
    iWR_DONE = 1'b0;
    chk("mid_in_hold", oBUSY, 1);
    step();
    step();
    iRST = 1'b1;
    step();
    chk("mid_rst_string", oSTRING, BLANK);
    chk("mid_rst_ack",    oACK,   0);
    chk("mid_rst_load",   oLOAD,  0);
    chk("mid_rst_owner",  oOWNER, 0);
    chk("mid_rst_busy",   oBUSY,  0);
    chk("mid_rst_err",    oERR,   0);
    iRST = 1'b0;
    step();
    chk("mid_regrant_ack",    oACK,    4'b0001);
    chk("mid_regrant_owner",  oOWNER,  0);
    chk("mid_regrant_string", oSTRING, s_changed);
    iREQ = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_msg_arbiter.md
# lcd_msg_arbiter

Round-robin scheduler that shares the single 16-character LCD line writer between up to N_REQ message sources, such as the game FSM, guess checker and timer. It captures one requester's 128-bit string, pulses the writer to refresh, waits for the writer's completion and holds the message on screen for a minimum time before granting the next requester. It sits between the game-logic blocks and the LCD line writer, which consumes `oSTRING` and restarts on `oLOAD`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 50_000_000: minimum display time after write completes, ≥1.
- `WR_TIMEOUT`, 4_000_000: maximum cycles to wait for `iWR_DONE`, ≥2.
- `iCLK`  in  1  system clock; all logic on the rising edge.
- `iRST`  in  1  synchronous, active-high reset.
- `iREQ`  in  N_REQ  level request per source.
- `iMSG`  in  128*N_REQ  source k string at `[128*k+127:128*k]`; MSB byte is the leftmost character.
- `iWR_DONE`  in  1  writer finished all 16 characters; sampled only in WAIT_WR.
- `oACK`  out  N_REQ  one-hot, one-cycle pulse: source's string captured.
- `oSTRING`  out  128  latched string to the writer.
- `oLOAD`  out  1  one-cycle pulse that starts a writer refresh.
- `oOWNER`  out  3  index of last granted source.
- `oBUSY`  out  1  high whenever state ≠ IDLE.
- `oERR`  out  1  sticky write-timeout flag; cleared only by reset.

## Operation
- Reset values:
  - state IDLE.
  - `oSTRING` = 16×8'h20 (all spaces).
  - `oACK` = 0, `oLOAD` = 0, `oBUSY` = 0, `oERR` = 0, `oOWNER` = 0.
  - Internal last-owner pointer = N_REQ-1, so source 0 has first priority.
  - Counters = 0.
- States: IDLE → LOAD → WAIT_WR → HOLD → IDLE.
- **IDLE:** if any `iREQ` bit is high, pick the first set bit scanning from (last_owner+1) mod N_REQ upward with wrap. Then:
  - Register `oSTRING` ← selected slice.
  - Set `oOWNER` and last_owner to the selected index.
  - Assert `oACK[sel]`.
  - Go to LOAD.
  - If no request is present, remain in IDLE; all outputs hold.
- **LOAD:** `oACK` ← 0, `oLOAD` ← 1, go to WAIT_WR.
- **WAIT_WR:**
  - `oLOAD` ← 0.
  - If `iWR_DONE` = 1: counter ← 0, go to HOLD.
  - Else if the counter reaches WR_TIMEOUT-1: `oERR` ← 1, counter ← 0, go to HOLD.
  - Else increment the counter.
  - If done and timeout coincide, done wins and `oERR` is unchanged.
- **HOLD:** count from 0 to HOLD_CYCLES-1, then go to IDLE; the counter clears on exit.
- `iREQ` is sampled only in IDLE. Changes to `iREQ` or `iMSG` in other states have no effect, and `oSTRING` is stable from capture until the next grant.
- A source that keeps `iREQ` high after `oACK` is served again in its round-robin turn; sources drop `iREQ` on `oACK`.
- Reset asserted in any state returns every register to its reset value on the next edge, aborting the transaction. No `oACK` or `oLOAD` is emitted in the reset cycle.
- Counter width is ceil(log2(max(HOLD_CYCLES, WR_TIMEOUT))). The counter is shared between WAIT_WR and HOLD.

## Timing
- Request seen at edge t (IDLE):
  - `oACK`, `oSTRING`, `oOWNER` and `oBUSY` = 1 are visible after t.
  - `oLOAD` is high for the cycle after t+1.
  - `iWR_DONE` is sampled from edge t+2 onward.
- Done sampled at edge d: HOLD occupies HOLD_CYCLES cycles; IDLE is re-entered at d+HOLD_CYCLES and `oBUSY` = 0 after that edge.
- The earliest next grant is at edge d+HOLD_CYCLES+1.
- Back-to-back service, done returned immediately: grant period = HOLD_CYCLES+3 cycles.
- Timeout path: `oERR` rises WR_TIMEOUT edges after entering WAIT_WR, then HOLD runs as normal.
- `iWR_DONE` high during LOAD or HOLD is ignored.

## Test plan
All scenarios use N_REQ=4, HOLD_CYCLES=8, WR_TIMEOUT=16.

- **Reset:** assert `iRST` 2 cycles → `oSTRING` = 128'h2020…20, all other outputs 0.
- **Single request:** `iREQ` = 4'b0100 with iMSG[2] = "GUESS: 42       " and `iWR_DONE` pulsed 3 cycles after `oLOAD` → `oACK` = 4'b0100 for 1 cycle, `oLOAD` for 1 cycle, `oOWNER` = 2, `oSTRING` equal to that string; `oBUSY` drops exactly 8 cycles after done.
- **Round robin:** hold `iREQ` = 4'b1111 continuously with immediate done → grant order 0,1,2,3,0, each grant 11 cycles apart.
- **Late change:** change iMSG[0] and drop `iREQ[0]` during WAIT_WR → `oSTRING` unchanged, no extra `oACK`.
- **Timeout:** never assert `iWR_DONE` → `oERR` = 1 sixteen cycles after entering WAIT_WR, then HOLD for 8 cycles and return to IDLE; `oERR` stays 1 until reset.
- **Reset mid-operation:** assert `iRST` in HOLD with `iREQ` = 4'b0011 → all outputs reset next edge; after release the first grant is source 0, not source 1.
